mac_acc: RTL and testbench

Signed multiply-accumulate back end that sits directly downstream of the `mul16_16` combinational multiplier. It consumes the 32-bit signed product stream over a valid/ready handshake and accumulates a frame of products into a guard-bit accumulator. When the frame ends, it emits one rounded, right-shifted and saturated result together with status flags. It is the registered stage that closes the multiplier's datapath into a dot-product engine.

---
 rtl/mac_acc_pkg.sv | 22 ++
 rtl/mac_round_sat.sv | 39 +++
 rtl/mac_acc.sv | 101 ++++++++++
 tb/tb_mac_acc.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_acc_pkg.sv
// Shared types and defaults for the mac_acc multiply-accumulate back end.
package mac_acc_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_IN_W  = 32;
  localparam int DEF_ACC_W = 40;
  localparam int DEF_OUT_W = 32;
  localparam int DEF_SHIFT = 0;

  localparam int              COUNT_W   = 16;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 16'hFFFF;

  // Frame length counter that sticks at its maximum instead of wrapping.
  function automatic logic [COUNT_W-1:0] count_inc(input logic [COUNT_W-1:0] c);
    return (c == COUNT_MAX) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/mac_round_sat.sv
// Combinational round-half-up, arithmetic right shift and clamp of the accumulator.
module mac_round_sat #(
  parameter int ACC_W = 40,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] data,
  output logic             sat
);

  // One extra bit so the rounding bias can never wrap the most positive sum.
  localparam int RW = ACC_W + 1;

  localparam logic signed [RW-1:0] RND   = RW'((64'd1 << SHIFT) >> 1);
  localparam logic signed [RW-1:0] MAX_V = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_V = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [RW-1:0] ext;
  logic signed [RW-1:0] biased;
  logic signed [RW-1:0] shifted;

  assign ext     = $signed({acc[ACC_W-1], acc});
  assign biased  = ext + RND;
  assign shifted = biased >>> SHIFT;

  always_comb begin
    data = shifted[OUT_W-1:0];
    sat  = 1'b0;
    if (shifted > MAX_V) begin
      data = MAX_V[OUT_W-1:0];
      sat  = 1'b1;
    end else if (shifted < MIN_V) begin
      data = MIN_V[OUT_W-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/mac_acc.sv
// Frame-based signed multiply-accumulate stage: sums a product stream into a
// guard-bit accumulator and emits one rounded, saturated result per frame.
module mac_acc
  import mac_acc_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_ovf,
  output logic [15:0]      out_count
);

  state_t state;
  state_t state_next;

  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [ACC_W-1:0]   in_ext;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] count_next;
  logic               ovf;
  logic               add_ovf;
  logic               beat;
  logic [OUT_W-1:0]   res_data;
  logic               res_sat;

  // Ready is a pure function of state; reset only forces it low while held.
  assign in_ready   = (state == ACC) && !rst;
  assign beat       = in_valid && in_ready;
  assign in_ext     = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign acc_sum    = acc + in_ext;
  assign add_ovf    = (acc[ACC_W-1] == in_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
  assign count_next = count_inc(count);

  mac_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .acc  (acc_sum),
    .data (res_data),
    .sat  (res_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACC:     if (beat && in_last) state_next = HOLD;
      HOLD:    if (out_ready)       state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  // The result is captured from the post-add value so the last product counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else if (beat) begin
      acc   <= acc_sum;
      count <= count_next;
      if (add_ovf) ovf <= 1'b1;
      if (in_last) begin
        out_valid <= 1'b1;
        out_data  <= res_data;
        out_sat   <= res_sat;
        out_ovf   <= ovf | add_ovf;
        out_count <= count_next;
      end
    end else if (state == HOLD && out_ready) begin
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_acc.sv
// Self-checking bench for mac_acc: a frame-level arithmetic model feeds a
// scoreboard, with literal expectations pinning the model on the key vectors.
module tb_mac_acc;

  typedef struct packed {
    logic [31:0] data;
    logic        sat;
    logic        ovf;
    logic [15:0] count;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid0;
  logic        in_valid1;
  logic        in_last;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [31:0] out_data0, out_data1;
  logic        out_sat0, out_sat1;
  logic        out_ovf0, out_ovf1;
  logic [15:0] out_count0, out_count1;

  res_t        exp0[$];
  res_t        exp1[$];
  res_t        last0;
  res_t        last1;
  logic [31:0] frame_q[$];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mac_acc dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_data  (out_data0),
    .out_sat   (out_sat0),
    .out_ovf   (out_ovf0),
    .out_count (out_count0)
  );

  mac_acc #(.SHIFT(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .out_sat   (out_sat1),
    .out_ovf   (out_ovf1),
    .out_count (out_count1)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Exact frame sum with 40-bit two's-complement wrap, then round/shift/clamp.
  function automatic res_t modelFrame(input int shift);
    longint acc = 0;
    longint r;
    longint lim = 64'sd1 <<< 39;
    res_t   res;
    int     n;
    res.ovf = 1'b0;
    res.sat = 1'b0;
    foreach (frame_q[i]) begin
      acc += longint'($signed(frame_q[i]));
      if (acc >= lim) begin
        acc -= 2 * lim;
        res.ovf = 1'b1;
      end else if (acc < -lim) begin
        acc += 2 * lim;
        res.ovf = 1'b1;
      end
    end
    if (shift > 0) r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    else           r = acc;
    if (r > 64'sd2147483647) begin
      r = 64'sd2147483647;
      res.sat = 1'b1;
    end else if (r < -64'sd2147483648) begin
      r = -64'sd2147483648;
      res.sat = 1'b1;
    end
    res.data  = r[31:0];
    n         = frame_q.size();
    res.count = (n > 65535) ? 16'hFFFF : 16'(n);
    return res;
  endfunction

  // Scoreboard: every cycle a result is shown it must match the pending model entry.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("dut0 ready_vs_valid", in_ready0, !out_valid0);
      checkOutput("dut1 ready_vs_valid", in_ready1, !out_valid1);
      if (out_valid0) begin
        if (exp0.size() == 0) begin
          checks++;
          $display("[TB] FAIL dut0 unexpected result: got 0x%0h, expected none", out_data0);
        end else begin
          checkOutput("dut0 data",  out_data0,  exp0[0].data);
          checkOutput("dut0 sat",   out_sat0,   exp0[0].sat);
          checkOutput("dut0 ovf",   out_ovf0,   exp0[0].ovf);
          checkOutput("dut0 count", out_count0, exp0[0].count);
          if (out_ready) begin
            last0 = '{data: out_data0, sat: out_sat0, ovf: out_ovf0, count: out_count0};
            void'(exp0.pop_front());
          end
        end
      end
      if (out_valid1) begin
        if (exp1.size() == 0) begin
          checks++;
          $display("[TB] FAIL dut1 unexpected result: got 0x%0h, expected none", out_data1);
        end else begin
          checkOutput("dut1 data",  out_data1,  exp1[0].data);
          checkOutput("dut1 sat",   out_sat1,   exp1[0].sat);
          checkOutput("dut1 ovf",   out_ovf1,   exp1[0].ovf);
          checkOutput("dut1 count", out_count1, exp1[0].count);
          if (out_ready) begin
            last1 = '{data: out_data1, sat: out_sat1, ovf: out_ovf1, count: out_count1};
            void'(exp1.pop_front());
          end
        end
      end
    end
  end

  // Streams frame_q into the selected DUT, one beat per accepted handshake.
  task automatic applyStimulus(input int sel);
    int t;
    if (sel == 0) exp0.push_back(modelFrame(0));
    else          exp1.push_back(modelFrame(1));
    foreach (frame_q[i]) begin
      in_data = frame_q[i];
      in_last = (i == frame_q.size() - 1);
      if (sel == 0) in_valid0 = 1'b1;
      else          in_valid1 = 1'b1;
      t = 0;
      @(negedge clk);
      while (!((sel == 0) ? in_ready0 : in_ready1) && t < 50) begin
        t++;
        @(negedge clk);
      end
      if (t >= 50) begin
        checks++;
        $display("[TB] FAIL beat accept timeout: got in_ready=0, expected 1 within 50 cycles");
      end
      @(posedge clk);
      #1;
    end
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic waitDrain(input int sel);
    int t = 0;
    while (((sel == 0) ? exp0.size() : exp1.size()) != 0 && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (((sel == 0) ? exp0.size() : exp1.size()) != 0) begin
      checks++;
      $display("[TB] FAIL result timeout: got no result, expected one within 400 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset in_ready",  in_ready0,  1'b0);
    checkOutput("reset out_valid", out_valid0, 1'b0);
    checkOutput("reset out_data",  out_data0,  32'h0);
    checkOutput("reset out_count", out_count0, 16'h0);
    checkOutput("reset in_ready1", in_ready1,  1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("ready after reset", in_ready0, 1'b1);
    @(posedge clk);
    #1;

    frame_q = '{32'h3FFF0001, 32'h3FFF0001};
    applyStimulus(0);
    waitDrain(0);
    checkOutput("f1 data",  last0.data,  32'h7FFE0002);
    checkOutput("f1 count", last0.count, 16'd2);
    checkOutput("f1 sat",   last0.sat,   1'b0);

    frame_q = '{32'hFFFD0000, 32'h01000000};
    applyStimulus(0);
    waitDrain(0);
    checkOutput("f2 data", last0.data, 32'h00FD0000);
    checkOutput("f2 sat",  last0.sat,  1'b0);

    frame_q = '{32'h3FFF0001, 32'h3FFF0001, 32'h3FFF0001, 32'h3FFF0001};
    applyStimulus(0);
    waitDrain(0);
    checkOutput("sat4 data",  last0.data,  32'h7FFFFFFF);
    checkOutput("sat4 sat",   last0.sat,   1'b1);
    checkOutput("sat4 ovf",   last0.ovf,   1'b0);
    checkOutput("sat4 count", last0.count, 16'd4);

    frame_q = '{32'd3};
    applyStimulus(1);
    waitDrain(1);
    checkOutput("shift1 +3", last1.data, 32'd2);
    frame_q = '{32'hFFFFFFFD};
    applyStimulus(1);
    waitDrain(1);
    checkOutput("shift1 -3", last1.data, 32'hFFFFFFFF);

    frame_q.delete();
    repeat (257) frame_q.push_back(32'h80000000);
    applyStimulus(0);
    waitDrain(0);
    checkOutput("wrap ovf",   last0.ovf,   1'b1);
    checkOutput("wrap data",  last0.data,  32'h7FFFFFFF);
    checkOutput("wrap sat",   last0.sat,   1'b1);
    checkOutput("wrap count", last0.count, 16'd257);

    // Result held back; products offered meanwhile must be ignored.
    out_ready = 1'b0;
    frame_q = '{32'h00000011};
    applyStimulus(0);
    in_valid0 = 1'b1;
    in_data   = 32'hDEAD0000;
    in_last   = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("hold out_valid", out_valid0, 1'b1);
      checkOutput("hold in_ready",  in_ready0,  1'b0);
      checkOutput("hold out_data",  out_data0,  32'h00000011);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    in_data   = 32'd7;
    frame_q   = '{32'd7};
    exp0.push_back(modelFrame(0));
    @(negedge clk);
    checkOutput("release in_ready before", in_ready0, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("release in_ready after", in_ready0, 1'b1);
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    in_last   = 1'b0;
    waitDrain(0);
    checkOutput("next frame data",  last0.data,  32'd7);
    checkOutput("next frame count", last0.count, 16'd1);

    // Abandon a frame part-way with reset.
    in_valid0 = 1'b1;
    in_data   = 32'h00000100;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst       = 1'b1;
    in_valid0 = 1'b0;
    @(negedge clk);
    checkOutput("rst in_ready", in_ready0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst out_valid", out_valid0, 1'b0);
    checkOutput("rst out_data",  out_data0,  32'h0);
    checkOutput("rst out_count", out_count0, 16'h0);
    checkOutput("rst out_ovf",   out_ovf0,   1'b0);
    checkOutput("rst out_sat",   out_sat0,   1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    frame_q = '{32'h00000005};
    applyStimulus(0);
    waitDrain(0);
    checkOutput("post-rst data",  last0.data,  32'd5);
    checkOutput("post-rst count", last0.count, 16'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
